// File: rtl/sample_pkt_stream_pkg.sv
// Shared types and widths for the sample packetiser.
package sample_pkt_stream_pkg;

    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_HOLD_LAST = 2'd2,
        ST_DRAIN     = 2'd3
    } state_e;

    // One FIFO entry: packed data word plus its end-of-packet tag.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

endpackage

// File: rtl/sample_pkt_stream_if.sv
// Outbound AXI-Stream bundle of the sample packetiser.
interface sample_pkt_stream_if;
    import sample_pkt_stream_pkg::*;

    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/sample_pkt_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while not empty.
module sample_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO only proceeds when the same-cycle pop frees a slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array; contents need no reset since empty gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sample_pkt_stream.sv
// Captures one packet of 16-bit samples per trigger toggle, packs pairs into
// 32-bit words and streams them out through a small FWFT FIFO.
module sample_pkt_stream
    import sample_pkt_stream_pkg::*;
#(
    parameter int PKT_WORDS  = 256,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                trig_in,
    sample_pkt_stream_if.master m_axis,
    output logic                irq,
    output logic                busy,
    output logic [OVF_W-1:0]    overflow_cnt
);
    localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WCNT_W = $clog2(PKT_WORDS + 1);

    state_e              state_q, state_d;
    logic                trig_q;
    logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                half_q, half_d;
    logic [SAMPLE_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                irq_q, irq_d;
    logic                busy_q, busy_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;

    logic                trig_edge;
    logic [DATA_W-1:0]   cap_word;
    logic                push, pop;
    word_t               push_word, fifo_rdata;
    logic                fifo_full, fifo_empty;

    assign trig_edge = trig_in ^ trig_q;
    // Earlier sample of the pair sits in the low half.
    assign cap_word  = {sample_in, lo_q};
    assign pop       = m_axis.m_tready & ~fifo_empty;

    assign m_axis.m_tvalid = ~fifo_empty;
    assign m_axis.m_tdata  = fifo_empty ? '0 : fifo_rdata.data;
    assign m_axis.m_tlast  = ~fifo_empty & fifo_rdata.last;
    assign irq             = irq_q;
    assign busy            = busy_q;
    assign overflow_cnt    = ovf_q;

    // Next-state and capture/push decisions for the packet FSM.
    always_comb begin
        state_d   = state_q;
        dec_cnt_d = dec_cnt_q;
        wcnt_d    = wcnt_q;
        half_d    = half_q;
        lo_d      = lo_q;
        hold_d    = hold_q;
        irq_d     = 1'b0;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_word = '0;
        case (state_q)
            ST_IDLE: begin
                // A trigger edge landing with the irq pulse is deliberately dropped.
                if (trig_edge && !irq_q) begin
                    state_d   = ST_CAPTURE;
                    dec_cnt_d = '0;
                    wcnt_d    = '0;
                    half_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
                if (dec_cnt_q == '0) begin
                    if (!half_q) begin
                        lo_d   = sample_in;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == WCNT_W'(PKT_WORDS - 1)) begin
                            // The closing word is never lost: park it if no room.
                            if (!fifo_full) begin
                                push      = 1'b1;
                                push_word = '{last: 1'b1, data: cap_word};
                                state_d   = ST_DRAIN;
                            end else begin
                                hold_d  = cap_word;
                                state_d = ST_HOLD_LAST;
                            end
                        end else if (!fifo_full) begin
                            push      = 1'b1;
                            push_word = '{last: 1'b0, data: cap_word};
                        end else if (ovf_q != '1) begin
                            // Dropped words still count toward the packet length.
                            ovf_d = ovf_q + 1'b1;
                        end
                    end
                end
            end
            ST_HOLD_LAST: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = '{last: 1'b1, data: hold_q};
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_axis.m_tvalid && m_axis.m_tready && m_axis.m_tlast) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered FSM state, capture context and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            dec_cnt_q <= '0;
            wcnt_q    <= '0;
            half_q    <= 1'b0;
            lo_q      <= '0;
            hold_q    <= '0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_in;
            dec_cnt_q <= dec_cnt_d;
            wcnt_q    <= wcnt_d;
            half_q    <= half_d;
            lo_q      <= lo_d;
            hold_q    <= hold_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    sample_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
